// File: rtl/sb_io_pkg.sv
// Shared PIN_TYPE field encodings and common pin presets for the sb_io pad cell.
package sb_io_pkg;

  // Output-enable field, PIN_TYPE[5:4]
  localparam logic [1:0] OE_NONE = 2'b00;
  localparam logic [1:0] OE_ON   = 2'b01;
  localparam logic [1:0] OE_COMB = 2'b10;
  localparam logic [1:0] OE_REG  = 2'b11;

  // Output-data field, PIN_TYPE[3:2]
  localparam logic [1:0] OUT_DDR     = 2'b00;
  localparam logic [1:0] OUT_REG     = 2'b01;
  localparam logic [1:0] OUT_COMB    = 2'b10;
  localparam logic [1:0] OUT_REG_INV = 2'b11;

  // Input field, PIN_TYPE[1:0]
  localparam logic [1:0] IN_REG       = 2'b00;
  localparam logic [1:0] IN_COMB      = 2'b01;
  localparam logic [1:0] IN_REG_LATCH = 2'b10;
  localparam logic [1:0] IN_LATCH     = 2'b11;

  // Presets used by the port wrappers
  localparam logic [5:0] PIN_OUTPUT_REGISTERED              = 6'b0101_01;
  localparam logic [5:0] PIN_OUTPUT_REGISTERED_ENABLE_INPUT = 6'b1001_01;
  localparam logic [5:0] PIN_INPUT_REGISTERED               = 6'b0000_00;

endpackage

// File: rtl/sb_io_ff.sv
// Single cell flop: async active-high reset, clock enable, edge chosen by NEG_EDGE.
module sb_io_ff #(
  parameter logic NEG_EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic edge_clk;

  // Inverting the clock lets one flop description serve both edges.
  assign edge_clk = clk ^ NEG_EDGE;

  // Capture d on the selected edge when enabled; reset wins over enable.
  always_ff @(posedge edge_clk or posedge reset) begin
    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    if (reset)   q <= 1'b0;
    else if (ce) q <= d;
  end

endmodule

// File: rtl/sb_io.sv
// Single-pad I/O cell (SB_IO style): output/OE/input path selection, tri-state
// pad driver, optional weak pull-up and transparent input latch.
module sb_io
  import sb_io_pkg::*;
#(
  parameter logic [5:0] PIN_TYPE    = 6'b0000_01,
  parameter logic       PULLUP      = 1'b0,
  parameter logic       NEG_TRIGGER = 1'b0
) (
  input  logic clk,
  input  logic reset,
  inout  wire  package_pin,
  input  logic clock_enable,
  input  logic latch_input_value,
  input  logic d_out_0,
  input  logic d_out_1,
  input  logic output_enable,
  output logic d_in_0,
  output logic d_in_1
);

  localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];
  localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
  localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];

  logic q_out0, q_out1, q_oe, q_in0, q_in1;
  logic in_latch;
  logic in_ce;
  logic pad_in, pad_out, pad_drive;
  logic ddr_phase;

  // The input path always sees the resolved pad, including this cell's own drive.
  assign pad_in = package_pin;

  // Registered-latch input mode freezes the input flops while latch_input_value is high.
  assign in_ce = (IN_MODE == IN_REG_LATCH) ? (clock_enable & ~latch_input_value)
                                           : clock_enable;

  // High during the half-period that follows the active edge.
  assign ddr_phase = clk ^ NEG_TRIGGER;

  sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_q_out0 (
    .clk(clk), .reset(reset), .ce(clock_enable), .d(d_out_0), .q(q_out0));

  sb_io_ff #(.NEG_EDGE(~NEG_TRIGGER)) u_q_out1 (
    .clk(clk), .reset(reset), .ce(clock_enable), .d(d_out_1), .q(q_out1));

  sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_q_oe (
    .clk(clk), .reset(reset), .ce(clock_enable), .d(output_enable), .q(q_oe));

  sb_io_ff #(.NEG_EDGE(NEG_TRIGGER)) u_q_in0 (
    .clk(clk), .reset(reset), .ce(in_ce), .d(pad_in), .q(q_in0));

  sb_io_ff #(.NEG_EDGE(~NEG_TRIGGER)) u_q_in1 (
    .clk(clk), .reset(reset), .ce(in_ce), .d(pad_in), .q(q_in1));

  // Select pad data and drive enable from the output and OE mode fields.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    pad_out   = q_out0;
    pad_drive = 1'b0;
    unique case (OUT_MODE)
      OUT_DDR:     pad_out = ddr_phase ? q_out0 : q_out1;
      OUT_REG:     pad_out = q_out0;
      OUT_COMB:    pad_out = d_out_0;
      OUT_REG_INV: pad_out = ~q_out0;
    endcase
    unique case (OE_MODE)
      OE_NONE: pad_drive = 1'b0;
      OE_ON:   pad_drive = 1'b1;
      OE_COMB: pad_drive = output_enable;
      OE_REG:  pad_drive = q_oe;
    endcase
  end

  assign package_pin = pad_drive ? pad_out : 1'bz;

  // Weak pull-up only where the pin asks for one.
  if (PULLUP) begin : g_pullup
    pullup u_pullup (package_pin);
  end

  // Input latch exists only in the latched input mode.
  if (IN_MODE == IN_LATCH) begin : g_in_latch
    // Transparent while latch_input_value is low; holds while high; reset clears it.
    always_latch begin
      // NOTE: this level-sensitive storage is intentional, hence always_latch.
      if (reset)                   in_latch <= 1'b0;
      else if (!latch_input_value) in_latch <= pad_in;
    end
  end else begin : g_no_latch
    assign in_latch = 1'b0;
  end

  // Route the input-side sources onto d_in_0 / d_in_1 by input mode.
  always_comb begin
    d_in_0 = q_in0;
    d_in_1 = 1'b0;
    unique case (IN_MODE)
      IN_REG, IN_REG_LATCH: begin
        d_in_0 = q_in0;
        d_in_1 = q_in1;
      end
      IN_COMB:  d_in_0 = pad_in;
      IN_LATCH: d_in_0 = in_latch;
    endcase
  end

endmodule

// File: tb/tb_sb_io.sv
// Self-checking bench for sb_io: several cell configurations sharing stimulus,
// a vector table for the enable-input pin, and hand sequences for edge cases.
module tb_sb_io;
  import sb_io_pkg::*;

  logic clk = 1'b0;
  logic reset, ce, lat, d0, d1, oe;
  logic ext_en_oe, ext_val_oe, ext_in_val, ext_lat_val;

  wire pad_reg, pad_oe, pad_inp, pad_ddr, pad_lat, pad_neg;
  logic din0_reg, din1_reg, din0_oe, din1_oe, din0_in, din1_in;
  logic din0_ddr, din1_ddr, din0_lat, din1_lat, din0_neg, din1_neg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign pad_oe  = ext_en_oe ? ext_val_oe : 1'bz;
  assign pad_inp = ext_in_val;
  assign pad_lat = ext_lat_val;

  sb_io #(.PIN_TYPE(PIN_OUTPUT_REGISTERED)) u_reg (
    .clk(clk), .reset(reset), .package_pin(pad_reg), .clock_enable(ce),
    .latch_input_value(lat), .d_out_0(d0), .d_out_1(d1), .output_enable(oe),
    .d_in_0(din0_reg), .d_in_1(din1_reg));

  sb_io #(.PIN_TYPE(PIN_OUTPUT_REGISTERED_ENABLE_INPUT), .PULLUP(1'b1)) u_oe (
    .clk(clk), .reset(reset), .package_pin(pad_oe), .clock_enable(ce),
    .latch_input_value(lat), .d_out_0(d0), .d_out_1(d1), .output_enable(oe),
    .d_in_0(din0_oe), .d_in_1(din1_oe));

  sb_io #(.PIN_TYPE(PIN_INPUT_REGISTERED)) u_in (
    .clk(clk), .reset(reset), .package_pin(pad_inp), .clock_enable(ce),
    .latch_input_value(lat), .d_out_0(d0), .d_out_1(d1), .output_enable(oe),
    .d_in_0(din0_in), .d_in_1(din1_in));

  sb_io #(.PIN_TYPE(6'b0100_00)) u_ddr (
    .clk(clk), .reset(reset), .package_pin(pad_ddr), .clock_enable(ce),
    .latch_input_value(lat), .d_out_0(d0), .d_out_1(d1), .output_enable(oe),
    .d_in_0(din0_ddr), .d_in_1(din1_ddr));

  sb_io #(.PIN_TYPE(6'b0000_11)) u_lat (
    .clk(clk), .reset(reset), .package_pin(pad_lat), .clock_enable(ce),
    .latch_input_value(lat), .d_out_0(d0), .d_out_1(d1), .output_enable(oe),
    .d_in_0(din0_lat), .d_in_1(din1_lat));

  sb_io #(.PIN_TYPE(PIN_OUTPUT_REGISTERED), .NEG_TRIGGER(1'b1)) u_neg (
    .clk(clk), .reset(reset), .package_pin(pad_neg), .clock_enable(ce),
    .latch_input_value(lat), .d_out_0(d0), .d_out_1(d1), .output_enable(oe),
    .d_in_0(din0_neg), .d_in_1(din1_neg));

  typedef struct {
    logic ce, oe, d0, ext_en, ext_val;
    logic exp_pad, exp_din;
  } oe_vec_t;

  oe_vec_t vecs [9];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; lat = 1'b0; d0 = 1'b0; d1 = 1'b0; oe = 1'b0;
    ext_en_oe = 1'b0; ext_val_oe = 1'b0; ext_in_val = 1'b1; ext_lat_val = 1'b1;

    // ce, oe, d0, ext_en, ext_val, exp_pad, exp_din
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // undriven -> pull-up
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // external 0
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}; // external 1
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // drive registered 1
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // drive registered 0
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // released -> pull-up
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // drive 1 again
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // ce=0 holds 1
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // ce back, captures 0

    // Reset state: registers cleared even with the pads pulled high
    step(); step();
    check("rst_pad_reg", pad_reg, 1'b0);
    check("rst_din0_reg_in", din0_in, 1'b0);
    check("rst_din1_reg_in", din1_in, 1'b0);
    check("rst_latch", din0_lat, 1'b0);
    reset = 1'b0;
    #1;
    check("latch_transparent", din0_lat, 1'b1);

    // Registered output: one edge latency, clock_enable hold
    ce = 1'b1; d0 = 1'b0;
    step();
    check("reg_pad_0", pad_reg, 1'b0);
    d0 = 1'b1;
    #1;
    check("reg_pad_before_edge", pad_reg, 1'b0);
    step();
    check("reg_pad_1", pad_reg, 1'b1);
    check("reg_din0_own_drive", din0_reg, 1'b1);
    ce = 1'b0; d0 = 1'b0;
    step(); step();
    check("reg_ce0_hold", pad_reg, 1'b1);
    ce = 1'b1;
    step();
    check("reg_ce1_capture0", pad_reg, 1'b0);
    d0 = 1'b1;
    step();
    check("reg_pad_1_again", pad_reg, 1'b1);

    // Async reset mid-operation, then first capture after release
    #1 reset = 1'b1;
    #1;
    check("async_rst_pad", pad_reg, 1'b0);
    check("async_rst_inv_neg", pad_neg, 1'b0);
    step();
    reset = 1'b0; ce = 1'b1; d0 = 1'b1;
    #1;
    check("post_rst_no_edge", pad_reg, 1'b0);
    check("neg_before_fall", pad_neg, 1'b0);
    half();
    check("neg_after_fall", pad_neg, 1'b1);
    check("reg_ignores_fall", pad_reg, 1'b0);
    step();
    check("post_rst_first_edge", pad_reg, 1'b1);

    // Enable-input pin: combinational input sees external drive immediately
    oe = 1'b0; ext_en_oe = 1'b1; ext_val_oe = 1'b0;
    #1;
    check("oe_comb_in_same_cycle", din0_oe, 1'b0);
    step();
    for (int i = 0; i < 9; i++) begin
      ce = vecs[i].ce; oe = vecs[i].oe; d0 = vecs[i].d0;
      ext_en_oe = vecs[i].ext_en; ext_val_oe = vecs[i].ext_val;
      step();
      check($sformatf("oe_row%0d_pad", i), pad_oe, vecs[i].exp_pad);
      check($sformatf("oe_row%0d_din0", i), din0_oe, vecs[i].exp_din);
    end
    oe = 1'b0; ce = 1'b1;

    // Registered input: rising and falling samples, hold between edges
    ext_in_val = 1'b1;
    step();
    ext_in_val = 1'b0;
    half();
    check("in_rise_sample", din0_in, 1'b1);
    check("in_fall_sample", din1_in, 1'b0);
    step();
    check("in_next_rise", din0_in, 1'b0);
    ext_in_val = 1'b1;
    half();
    check("in_fall_sample_1", din1_in, 1'b1);
    check("in_hold_between", din0_in, 1'b0);
    ce = 1'b0;
    step();
    check("in_ce0_hold", din0_in, 1'b0);
    ce = 1'b1;
    step();
    check("in_ce1_capture", din0_in, 1'b1);

    // DDR output: clk-high half shows q_out0, clk-low half shows q_out1
    d0 = 1'b1; d1 = 1'b0;
    step();
    check("ddr_high_d0", pad_ddr, 1'b1);
    half();
    check("ddr_low_d1", pad_ddr, 1'b0);
    d0 = 1'b0; d1 = 1'b1;
    step();
    check("ddr_high_d0_b", pad_ddr, 1'b0);
    half();
    check("ddr_low_d1_b", pad_ddr, 1'b1);

    // Input latch: hold while latch_input_value=1, follow when released
    lat = 1'b0; ext_lat_val = 1'b0;
    #1;
    check("latch_follow_0", din0_lat, 1'b0);
    lat = 1'b1;
    #1 ext_lat_val = 1'b1;
    #1;
    check("latch_hold", din0_lat, 1'b0);
    step();
    check("latch_hold_over_edge", din0_lat, 1'b0);
    check("latch_din1_zero", din1_lat, 1'b0);
    lat = 1'b0;
    #1;
    check("latch_release", din0_lat, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
